l1_arbiter: RTL and testbench

- Responder to the L1 caches' line-fill and write-back requests; sits between the instruction and data L1 caches and physical memory.
- Accepts 128-bit line reads and writes from two L1 ports (I and D), grants one at a time, and forwards the granted request to the single pmem port.
- Buffers the returned line and answers the granted cache with a one-cycle response pulse.

---
 rtl/l1_arbiter.sv | 164 ++++++++++++++++
 tb/tb_l1_arbiter.sv | 488 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_arbiter.sv
// Round-robin arbiter between the I and D L1 caches in front of a single pmem port.
// One transaction in flight; the returned line is buffered per port and acked with a 1-cycle pulse.
module l1_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned LINE_WIDTH  = 128,
    parameter int unsigned OFFSET_BITS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  i_arb_read,
    input  logic [ADDR_WIDTH-1:0] i_arb_address,
    output logic [LINE_WIDTH-1:0] i_arb_rdata,
    output logic                  i_arb_resp,

    input  logic                  d_arb_read,
    input  logic                  d_arb_write,
    input  logic [ADDR_WIDTH-1:0] d_arb_address,
    input  logic [LINE_WIDTH-1:0] d_arb_wdata,
    output logic [LINE_WIDTH-1:0] d_arb_rdata,
    output logic                  d_arb_resp,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    typedef enum logic [2:0] {
        StIdle,
        StMemI,
        StMemD,
        StRespI,
        StRespD
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] AlignMask = {ADDR_WIDTH{1'b1}} << OFFSET_BITS;

    state_e                state_q, state_d;
    logic                  last_grant_q, last_grant_d;  // 0: I, 1: D
    logic                  pmem_read_q, pmem_read_d;
    logic                  pmem_write_q, pmem_write_d;
    logic [ADDR_WIDTH-1:0] pmem_address_q, pmem_address_d;
    logic [LINE_WIDTH-1:0] pmem_wdata_q, pmem_wdata_d;
    logic [LINE_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [LINE_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  i_resp_q, i_resp_d;
    logic                  d_resp_q, d_resp_d;

    logic pend_i;
    logic pend_d;
    logic sel_i;
    logic sel_d;

    // On contention, D wins unless it was the last port served.
    assign pend_i = i_arb_read;
    assign pend_d = d_arb_read | d_arb_write;
    assign sel_d  = pend_d & (~pend_i | ~last_grant_q);
    assign sel_i  = pend_i & ~sel_d;

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        pmem_read_d    = pmem_read_q;
        pmem_write_d   = pmem_write_q;
        pmem_address_d = pmem_address_q;
        pmem_wdata_d   = pmem_wdata_q;
        i_rdata_d      = i_rdata_q;
        d_rdata_d      = d_rdata_q;
        i_resp_d       = 1'b0;
        d_resp_d       = 1'b0;

        case (state_q)
            StIdle: begin
                if (sel_d) begin
                    state_d        = StMemD;
                    last_grant_d   = 1'b1;
                    pmem_address_d = d_arb_address & AlignMask;
                    pmem_wdata_d   = d_arb_wdata;
                    // read+write together is resolved as a write-back
                    pmem_write_d   = d_arb_write;
                    pmem_read_d    = ~d_arb_write;
                end else if (sel_i) begin
                    state_d        = StMemI;
                    last_grant_d   = 1'b0;
                    pmem_address_d = i_arb_address & AlignMask;
                    pmem_wdata_d   = d_arb_wdata;
                    pmem_write_d   = 1'b0;
                    pmem_read_d    = 1'b1;
                end
            end

            StMemI: begin
                if (pmem_resp) begin
                    state_d      = StRespI;
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                    i_rdata_d    = pmem_rdata;
                    i_resp_d     = 1'b1;
                end
            end

            StMemD: begin
                if (pmem_resp) begin
                    state_d      = StRespD;
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                    if (pmem_read_q) begin
                        d_rdata_d = pmem_rdata;
                    end
                    d_resp_d     = 1'b1;
                end
            end

            StRespI: state_d = StIdle;

            StRespD: state_d = StIdle;

            default: begin
                state_d      = StIdle;
                pmem_read_d  = 1'b0;
                pmem_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            last_grant_q   <= 1'b0;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
            i_rdata_q      <= '0;
            d_rdata_q      <= '0;
            i_resp_q       <= 1'b0;
            d_resp_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            pmem_read_q    <= pmem_read_d;
            pmem_write_q   <= pmem_write_d;
            pmem_address_q <= pmem_address_d;
            pmem_wdata_q   <= pmem_wdata_d;
            i_rdata_q      <= i_rdata_d;
            d_rdata_q      <= d_rdata_d;
            i_resp_q       <= i_resp_d;
            d_resp_q       <= d_resp_d;
        end
    end

    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = pmem_address_q;
    assign pmem_wdata   = pmem_wdata_q;
    assign i_arb_rdata  = i_rdata_q;
    assign d_arb_rdata  = d_rdata_q;
    assign i_arb_resp   = i_resp_q;
    assign d_arb_resp   = d_resp_q;

endmodule

// File: tb/tb_l1_arbiter.sv
// Scoreboard bench for l1_arbiter: a behavioural pmem records each transaction it sees,
// and every scenario task compares those records against the ones it queued up front.
module tb_l1_arbiter;

    typedef struct packed {
        logic [15:0]  addr;
        logic         rd;
        logic         wr;
        logic [127:0] wdata;
    } pm_t;

    typedef struct packed {
        logic         port;   // 0: I, 1: D
        logic [127:0] rdata;
    } rs_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         i_arb_read = 1'b0;
    logic [15:0]  i_arb_address = '0;
    logic [127:0] i_arb_rdata;
    logic         i_arb_resp;
    logic         d_arb_read = 1'b0;
    logic         d_arb_write = 1'b0;
    logic [15:0]  d_arb_address = '0;
    logic [127:0] d_arb_wdata = '0;
    logic [127:0] d_arb_rdata;
    logic         d_arb_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata = '0;
    logic         pmem_resp = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int viol = 0;
    int resp_lat = 3;
    int cnt = 0;
    bit busy = 1'b0;
    pm_t cur;

    pm_t obs_pm[$];
    pm_t exp_pm[$];
    int  obs_pm_cyc[$];
    int  presp_q[$];
    rs_t obs_rs[$];
    rs_t exp_rs[$];
    int  obs_rs_cyc[$];
    logic [127:0] exp_i_rdata = '0;
    logic [127:0] exp_d_rdata = '0;

    l1_arbiter dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_arb_read    (i_arb_read),
        .i_arb_address (i_arb_address),
        .i_arb_rdata   (i_arb_rdata),
        .i_arb_resp    (i_arb_resp),
        .d_arb_read    (d_arb_read),
        .d_arb_write   (d_arb_write),
        .d_arb_address (d_arb_address),
        .d_arb_wdata   (d_arb_wdata),
        .d_arb_rdata   (d_arb_rdata),
        .d_arb_resp    (d_arb_resp),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_address  (pmem_address),
        .pmem_wdata    (pmem_wdata),
        .pmem_rdata    (pmem_rdata),
        .pmem_resp     (pmem_resp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] mem_line(input logic [15:0] a);
        return {{7{16'hAAAA}}, a ^ 16'h1231};
    endfunction

    // Behavioural memory: answers each strobe after resp_lat cycles, flags protocol breaks.
    always @(negedge clk) begin
        if (pmem_read && pmem_write) viol++;
        if (!reset_n) begin
            busy = 1'b0;
            pmem_resp = 1'b0;
        end else if (pmem_resp) begin
            pmem_resp = 1'b0;
            busy = 1'b0;
            if (pmem_read || pmem_write) viol++;
        end else if (busy) begin
            if ({pmem_address, pmem_read, pmem_write, pmem_wdata} !== cur) viol++;
            cnt--;
            if (cnt <= 0) begin
                pmem_rdata = mem_line(pmem_address);
                pmem_resp = 1'b1;
                presp_q.push_back(cyc);
            end
        end else if (pmem_read || pmem_write) begin
            busy = 1'b1;
            cnt = resp_lat;
            cur = {pmem_address, pmem_read, pmem_write, pmem_wdata};
            obs_pm.push_back(cur);
            obs_pm_cyc.push_back(cyc);
        end
    end

    always @(negedge clk) begin
        if (reset_n && i_arb_resp) begin
            obs_rs.push_back({1'b0, i_arb_rdata});
            obs_rs_cyc.push_back(cyc);
        end
        if (reset_n && d_arb_resp) begin
            obs_rs.push_back({1'b1, d_arb_rdata});
            obs_rs_cyc.push_back(cyc);
        end
    end

    task automatic do_reset();
        i_arb_read = 1'b0;
        d_arb_read = 1'b0;
        d_arb_write = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        obs_pm.delete(); exp_pm.delete(); obs_pm_cyc.delete(); presp_q.delete();
        obs_rs.delete(); exp_rs.delete(); obs_rs_cyc.delete();
        viol = 0;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
    endtask

    // Holds the port's request until its resp is seen, then drops it (stimulus only).
    task automatic l1_wait(input bit port, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            #1;
            if (!port && i_arb_resp) begin
                i_arb_read = 1'b0;
                ok = 1'b1;
                break;
            end
            if (port && d_arb_resp) begin
                d_arb_read = 1'b0;
                d_arb_write = 1'b0;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({i_arb_rdata, d_arb_rdata, pmem_wdata, pmem_address, pmem_read, pmem_write,
             i_arb_resp, d_arb_resp} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got rd=%b wr=%b addr=%h ir=%b dr=%b, all required 0",
                     pmem_read, pmem_write, pmem_address, i_arb_resp, d_arb_resp);
        end
        repeat (4) @(negedge clk);
        #1;
        vectors++;
        if (obs_pm.size() != 0) begin
            miscompares++;
            $display("FAIL reset_idle_strobe: got %0d transactions, required 0", obs_pm.size());
        end
    endtask

    task automatic test_i_read();
        bit ok;
        int drv;
        pm_t o, e;
        rs_t ro, re;
        do_reset();
        resp_lat = 3;
        i_arb_address = 16'h1236;
        i_arb_read = 1'b1;
        drv = cyc;
        exp_pm.push_back('{addr: 16'h1230, rd: 1'b1, wr: 1'b0, wdata: d_arb_wdata});
        exp_i_rdata = mem_line(16'h1230);
        exp_rs.push_back('{port: 1'b0, rdata: exp_i_rdata});
        l1_wait(1'b0, ok);
        repeat (4) @(negedge clk);
        #1;
        vectors++;
        if (ok !== 1'b1 || obs_pm.size() != 1 || obs_rs.size() != 1) begin
            miscompares++;
            $display("FAIL i_read_count: got ok=%b pm=%0d rs=%0d, required 1 1 1",
                     ok, obs_pm.size(), obs_rs.size());
        end else begin
            o = obs_pm.pop_front(); e = exp_pm.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL i_read_pmem: got %h required %h", o, e);
            end
            vectors++;
            if (obs_pm_cyc[0] != drv + 1) begin
                miscompares++;
                $display("FAIL i_read_strobe_lat: got cycle %0d required %0d", obs_pm_cyc[0], drv + 1);
            end
            ro = obs_rs.pop_front(); re = exp_rs.pop_front();
            vectors++;
            if (ro !== re) begin
                miscompares++;
                $display("FAIL i_read_resp: got %h required %h", ro, re);
            end
            vectors++;
            if (obs_rs_cyc[0] != presp_q[0] + 1) begin
                miscompares++;
                $display("FAIL i_read_resp_lat: got cycle %0d required %0d",
                         obs_rs_cyc[0], presp_q[0] + 1);
            end
        end
        vectors++;
        if (i_arb_rdata !== exp_i_rdata || d_arb_rdata !== exp_d_rdata || viol != 0) begin
            miscompares++;
            $display("FAIL i_read_hold: got i=%h d=%h viol=%0d required i=%h d=%h viol=0",
                     i_arb_rdata, d_arb_rdata, viol, exp_i_rdata, exp_d_rdata);
        end
    endtask

    task automatic test_d_write();
        bit ok;
        pm_t o, e;
        rs_t ro, re;
        do_reset();
        resp_lat = 2;
        d_arb_address = 16'h80FF;
        d_arb_wdata = {8{16'h5555}};
        d_arb_write = 1'b1;
        exp_pm.push_back('{addr: 16'h80F0, rd: 1'b0, wr: 1'b1, wdata: {8{16'h5555}}});
        exp_rs.push_back('{port: 1'b1, rdata: exp_d_rdata});
        l1_wait(1'b1, ok);
        repeat (4) @(negedge clk);
        #1;
        vectors++;
        if (ok !== 1'b1 || obs_pm.size() != 1 || obs_rs.size() != 1) begin
            miscompares++;
            $display("FAIL d_write_count: got ok=%b pm=%0d rs=%0d, required 1 1 1",
                     ok, obs_pm.size(), obs_rs.size());
        end else begin
            o = obs_pm.pop_front(); e = exp_pm.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL d_write_pmem: got %h required %h", o, e);
            end
            ro = obs_rs.pop_front(); re = exp_rs.pop_front();
            vectors++;
            if (ro !== re) begin
                miscompares++;
                $display("FAIL d_write_resp: got %h required %h", ro, re);
            end
        end
        vectors++;
        if (d_arb_rdata !== exp_d_rdata || viol != 0) begin
            miscompares++;
            $display("FAIL d_write_rdata_kept: got %h viol=%0d required %h viol=0",
                     d_arb_rdata, viol, exp_d_rdata);
        end
    endtask

    task automatic test_contention();
        int n;
        pm_t o, e;
        rs_t ro, re;
        do_reset();
        resp_lat = 2;
        i_arb_address = 16'h2000;
        d_arb_address = 16'h3004;
        d_arb_wdata = {4{32'h0BADF00D}};
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) begin
                exp_pm.push_back('{addr: 16'h3000, rd: 1'b1, wr: 1'b0, wdata: {4{32'h0BADF00D}}});
                exp_rs.push_back('{port: 1'b1, rdata: mem_line(16'h3000)});
            end else begin
                exp_pm.push_back('{addr: 16'h2000, rd: 1'b1, wr: 1'b0, wdata: {4{32'h0BADF00D}}});
                exp_rs.push_back('{port: 1'b0, rdata: mem_line(16'h2000)});
            end
        end
        exp_d_rdata = mem_line(16'h3000);
        exp_i_rdata = mem_line(16'h2000);
        i_arb_read = 1'b1;
        d_arb_read = 1'b1;
        for (n = 0; n < 400 && obs_rs.size() < 4; n++) begin
            @(negedge clk);
            #1;
        end
        i_arb_read = 1'b0;
        d_arb_read = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        vectors++;
        if (obs_pm.size() != 4 || obs_rs.size() != 4) begin
            miscompares++;
            $display("FAIL contention_count: got pm=%0d rs=%0d, required 4 4",
                     obs_pm.size(), obs_rs.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                o = obs_pm.pop_front(); e = exp_pm.pop_front();
                ro = obs_rs.pop_front(); re = exp_rs.pop_front();
                vectors++;
                if (o !== e || ro !== re) begin
                    miscompares++;
                    $display("FAIL contention_order[%0d]: got port=%b addr=%h required port=%b addr=%h",
                             k, ro.port, o.addr, re.port, e.addr);
                end
            end
        end
        vectors++;
        if (i_arb_rdata !== exp_i_rdata || d_arb_rdata !== exp_d_rdata || viol != 0) begin
            miscompares++;
            $display("FAIL contention_rdata: got i=%h d=%h viol=%0d required i=%h d=%h",
                     i_arb_rdata, d_arb_rdata, viol, exp_i_rdata, exp_d_rdata);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit seen;
        pm_t o, e;
        do_reset();
        resp_lat = 2;
        i_arb_address = 16'h4013;
        i_arb_read = 1'b1;
        exp_pm.push_back('{addr: 16'h4010, rd: 1'b1, wr: 1'b0, wdata: d_arb_wdata});
        exp_pm.push_back('{addr: 16'h4020, rd: 1'b1, wr: 1'b0, wdata: d_arb_wdata});
        exp_i_rdata = mem_line(16'h4020);
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            #1;
            seen = i_arb_resp;
        end
        i_arb_address = 16'h4028;
        l1_wait(1'b0, ok);
        repeat (6) @(negedge clk);
        #1;
        vectors++;
        if (!seen || ok !== 1'b1 || obs_pm.size() != 2 || obs_rs.size() != 2) begin
            miscompares++;
            $display("FAIL b2b_count: got seen=%b ok=%b pm=%0d rs=%0d, required 1 1 2 2",
                     seen, ok, obs_pm.size(), obs_rs.size());
        end else begin
            vectors++;
            if (obs_pm_cyc[1] != presp_q[0] + 3) begin
                miscompares++;
                $display("FAIL b2b_regrant_lat: got cycle %0d required %0d",
                         obs_pm_cyc[1], presp_q[0] + 3);
            end
            for (int k = 0; k < 2; k++) begin
                o = obs_pm.pop_front(); e = exp_pm.pop_front();
                vectors++;
                if (o !== e) begin
                    miscompares++;
                    $display("FAIL b2b_pmem[%0d]: got %h required %h", k, o.addr, e.addr);
                end
            end
        end
        vectors++;
        if (i_arb_rdata !== exp_i_rdata) begin
            miscompares++;
            $display("FAIL b2b_rdata: got %h required %h", i_arb_rdata, exp_i_rdata);
        end
    endtask

    task automatic test_reset_mid_op();
        bit ok;
        bit seen;
        pm_t o, e;
        rs_t ro, re;
        do_reset();
        resp_lat = 6;
        d_arb_address = 16'h1111;
        d_arb_wdata = {2{64'hFEEDFACE_CAFEBABE}};
        d_arb_write = 1'b1;
        for (int k = 0; k < 2; k++)
            exp_pm.push_back('{addr: 16'h1110, rd: 1'b0, wr: 1'b1,
                               wdata: {2{64'hFEEDFACE_CAFEBABE}}});
        exp_rs.push_back('{port: 1'b1, rdata: '0});
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            #1;
            seen = pmem_write;
        end
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (!seen || {i_arb_rdata, d_arb_rdata, pmem_wdata, pmem_address, pmem_read,
                      pmem_write, i_arb_resp, d_arb_resp} !== '0) begin
            miscompares++;
            $display("FAIL midreset_async: got seen=%b wr=%b addr=%h wdata=%h, required 1 and 0s",
                     seen, pmem_write, pmem_address, pmem_wdata);
        end
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (obs_rs.size() != 0) begin
            miscompares++;
            $display("FAIL midreset_no_resp: got %0d responses, required 0", obs_rs.size());
        end
        reset_n = 1'b1;
        l1_wait(1'b1, ok);
        repeat (4) @(negedge clk);
        #1;
        vectors++;
        if (ok !== 1'b1 || obs_pm.size() != 2 || obs_rs.size() != 1) begin
            miscompares++;
            $display("FAIL midreset_regrant: got ok=%b pm=%0d rs=%0d, required 1 2 1",
                     ok, obs_pm.size(), obs_rs.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                o = obs_pm.pop_front(); e = exp_pm.pop_front();
                vectors++;
                if (o !== e) begin
                    miscompares++;
                    $display("FAIL midreset_pmem[%0d]: got %h required %h", k, o, e);
                end
            end
            ro = obs_rs.pop_front(); re = exp_rs.pop_front();
            vectors++;
            if (ro !== re) begin
                miscompares++;
                $display("FAIL midreset_resp: got %h required %h", ro, re);
            end
        end
    endtask

    task automatic test_illegal_rw();
        bit ok;
        pm_t o, e;
        do_reset();
        resp_lat = 2;
        d_arb_address = 16'h7777;
        d_arb_wdata = {16{8'h3C}};
        d_arb_read = 1'b1;
        d_arb_write = 1'b1;
        exp_pm.push_back('{addr: 16'h7770, rd: 1'b0, wr: 1'b1, wdata: {16{8'h3C}}});
        l1_wait(1'b1, ok);
        repeat (4) @(negedge clk);
        #1;
        vectors++;
        if (ok !== 1'b1 || obs_pm.size() != 1 || obs_rs.size() != 1) begin
            miscompares++;
            $display("FAIL illegal_rw_count: got ok=%b pm=%0d rs=%0d, required 1 1 1",
                     ok, obs_pm.size(), obs_rs.size());
        end else begin
            o = obs_pm.pop_front(); e = exp_pm.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL illegal_rw_pmem: got rd=%b wr=%b addr=%h required rd=%b wr=%b addr=%h",
                         o.rd, o.wr, o.addr, e.rd, e.wr, e.addr);
            end
        end
        vectors++;
        if (d_arb_rdata !== exp_d_rdata || viol != 0) begin
            miscompares++;
            $display("FAIL illegal_rw_rdata: got %h viol=%0d required %h viol=0",
                     d_arb_rdata, viol, exp_d_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_i_read();
        test_d_write();
        test_contention();
        test_back_to_back();
        test_reset_mid_op();
        test_illegal_rw();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
